magic_device_reader: RTL and testbench

MAGIC_DEVICE_READER -- requirements
Module: magic_device_reader

---
 rtl/magic_device_reader_pkg.sv | 14 +
 rtl/magic_reader_fifo.sv | 65 ++++++
 rtl/magic_device_reader.sv | 122 ++++++++++++
 tb/tb_magic_device_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/magic_device_reader_pkg.sv
// Shared types and defaults for the magic device burst reader.
package magic_device_reader_pkg;

  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned DEFAULT_SEL_W  = 12;
  localparam int unsigned LEN_W          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/magic_reader_fifo.sv
// Response buffer: DEPTH entries of WIDTH bits with an occupancy count.
// The read port shows zero while empty so downstream sees clean data.
module magic_reader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers (wrap naturally, DEPTH is 2^n) and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/magic_device_reader.sv
// Burst reader: accepts a (channel, length) request, pulls words from the
// magic device one per cycle under FIFO credit, and streams them out with
// a last marker on the final word.
module magic_device_reader
  import magic_device_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned SEL_W  = DEFAULT_SEL_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_select,
  input  logic [LEN_W-1:0]  req_len,
  output logic [SEL_W-1:0]  read_select,
  output logic              read_ready,
  input  logic              read_valid,
  input  logic [DATA_W-1:0] read_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  state_e             state_q, state_d;
  logic [LEN_W:0]     remaining_q, remaining_d;
  logic               pending_q, pending_d;
  logic               pending_last_q, pending_last_d;
  logic [SEL_W-1:0]   read_select_q, read_select_d;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [DATA_W:0]    fifo_out;
  logic               credit_ok;
  logic               beat;

  // A word in flight (pending) already owns a FIFO slot, so it counts
  // against the credit; this keeps the FIFO from ever overflowing.
  always_comb begin
    credit_ok = (({1'b0, fifo_count} + {{CW{1'b0}}, pending_q}) < (CW+1)'(DEPTH));
  end

  // Next-state, burst bookkeeping and handshake outputs
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    read_select_d  = read_select_q;
    req_ready      = (state_q == IDLE);
    read_ready     = (state_q == BURST) && (remaining_q != '0) && credit_ok;
    beat           = read_ready && read_valid;
    pending_d      = beat;
    pending_last_d = beat && (remaining_q == (LEN_W+1)'(1));

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          read_select_d = req_select;
          remaining_d   = {1'b0, req_len} + 1'b1;
          state_d       = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (LEN_W+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pending_q && pending_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      read_select_q  <= '0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      pending_q      <= pending_d;
      pending_last_q <= pending_last_d;
      read_select_q  <= read_select_d;
    end
  end

  assign read_select = read_select_q;
  assign fifo_pop    = !fifo_empty && rsp_ready;

  magic_reader_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (pending_q),
    .push_data_i ({pending_last_q, read_data}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_out),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_out[DATA_W-1:0];
  assign rsp_last  = fifo_out[DATA_W];

endmodule

// File: tb/tb_magic_device_reader.sv
// Bench for magic_device_reader: randomized device/consumer timing checked
// against a word-order scoreboard built from the requested bursts.
module tb_magic_device_reader;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_select;
  logic [7:0]  req_len;
  logic [11:0] read_select;
  logic        read_ready;
  logic        read_valid;
  logic [63:0] read_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_last;

  magic_device_reader #(
    .DATA_W (64),
    .SEL_W  (12),
    .DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_select  (req_select),
    .req_len     (req_len),
    .read_select (read_select),
    .read_ready  (read_ready),
    .read_valid  (read_valid),
    .read_data   (read_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [63:0] dev_q[$];   // words the device will hand out, in order
  logic [64:0] exp_q[$];   // {last, data} expected on the response stream
  logic [11:0] cur_sel;
  int hs_total, pop_total, rr_total, cyc;
  int first_hs, last_hs, first_rsp;

  // One clock cycle; called just after a negedge with inputs applied.
  task automatic step();
    bit          hs, pop;
    logic [63:0] w;
    logic [64:0] e;
    w   = {$urandom, $urandom};
    hs  = read_ready && read_valid;
    pop = rsp_valid && rsp_ready;
    if (read_ready) begin
      rr_total++;
      checks++;
      if (read_select !== cur_sel) begin
        failures++;
        $display("FAIL read_select: got %h want %h", read_select, cur_sel);
      end
    end
    if (hs) begin
      hs_total++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      checks++;
      if (dev_q.size() == 0) begin
        failures++;
        $display("FAIL extra_handshake: got handshake beyond burst length want none");
      end else begin
        w = dev_q.pop_front();
      end
    end
    if (rsp_valid && first_rsp < 0) first_rsp = cyc;
    if (pop) begin
      pop_total++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL extra_word: got %h last=%b want no word", rsp_data, rsp_last);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_last, rsp_data} !== e) begin
          failures++;
          $display("FAIL rsp_word: got last=%b data=%h want last=%b data=%h",
                   rsp_last, rsp_data, e[64], e[63:0]);
        end
      end
    end
    checks++;
    if (hs_total - pop_total > DEPTH) begin
      failures++;
      $display("FAIL credit: got %0d words outstanding want <= %0d", hs_total - pop_total, DEPTH);
    end
    @(posedge clock);
    @(negedge clock);
    read_data = w;
    cyc++;
  endtask

  // Issue one burst and run it to completion under the given timing.
  task automatic run_burst(input logic [11:0] sel, input logic [7:0] len,
                           input int vprob, input int rprob, input bit seq,
                           input int hold, input int st_lo, input int st_hi,
                           input int abort_at);
    logic [63:0] w;
    int k;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    for (int i = 0; i <= int'(len); i++) begin
      w = seq ? 64'(i + 1) : {$urandom, $urandom};
      dev_q.push_back(w);
      exp_q.push_back({(i == int'(len)), w});
    end
    cur_sel = sel; hs_total = 0; pop_total = 0; rr_total = 0;
    first_hs = -1; last_hs = -1; first_rsp = -1;
    req_valid = 1'b1; req_select = sel; req_len = len;
    read_valid = 1'b0; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0; req_select = 12'($urandom); req_len = 8'($urandom);
    for (k = 1; k <= 4000 && exp_q.size() != 0; k++) begin
      if (abort_at > 0 && hs_total >= abort_at) return;
      if (hold > 0 && k == hold + 1) begin
        checks++;
        if (hs_total !== DEPTH || read_ready !== 1'b0) begin
          failures++;
          $display("FAIL backpressure: got hs=%0d read_ready=%b want hs=%0d read_ready=0",
                   hs_total, read_ready, DEPTH);
        end
      end
      read_valid = (k >= st_lo && k <= st_hi) ? 1'b0 : ($urandom_range(99) < vprob);
      rsp_ready  = (k <= hold) ? 1'b0 : ($urandom_range(99) < rprob);
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL burst_timeout: got %0d words missing want 0", exp_q.size());
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after: got req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    end
    read_valid = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    read_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL quiet: got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_select = '0; req_len = '0;
    read_valid = 1'b0; read_data = '0; rsp_ready = 1'b0; cur_sel = '0; cyc = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({req_ready, read_ready, rsp_valid, rsp_last} !== 4'b1000 || rsp_data !== 64'd0
        || read_select !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rr=%b rd=%b rv=%b rl=%b data=%h sel=%h want 1 0 0 0 0 0",
               req_ready, read_ready, rsp_valid, rsp_last, rsp_data, read_select);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    run_burst(12'h005, 8'd0, 100, 100, 1'b0, 0, 0, -1, 0);
    checks++;
    if (rr_total !== 1 || hs_total !== 1) begin
      failures++;
      $display("FAIL single_pulse: got read_ready cycles=%0d hs=%0d want 1 1", rr_total, hs_total);
    end
    checks++;
    if (first_rsp - first_hs !== 2) begin
      failures++;
      $display("FAIL single_latency: got %0d want 2", first_rsp - first_hs);
    end
  endtask

  task automatic test_streaming();
    run_burst(12'h0A1, 8'd7, 100, 100, 1'b1, 0, 0, -1, 0);
    checks++;
    if (hs_total !== 8 || rr_total !== 8 || last_hs - first_hs !== 7) begin
      failures++;
      $display("FAIL stream_rate: got hs=%0d rr=%0d span=%0d want 8 8 7",
               hs_total, rr_total, last_hs - first_hs);
    end
    checks++;
    if (first_rsp - first_hs !== 2) begin
      failures++;
      $display("FAIL stream_latency: got %0d want 2", first_rsp - first_hs);
    end
  endtask

  task automatic test_backpressure();
    run_burst(12'h7F0, 8'd9, 100, 100, 1'b0, 20, 0, -1, 0);
    checks++;
    if (hs_total !== 10 || pop_total !== 10) begin
      failures++;
      $display("FAIL backpressure_total: got hs=%0d pops=%0d want 10 10", hs_total, pop_total);
    end
  endtask

  task automatic test_device_stall();
    run_burst(12'h123, 8'd3, 100, 100, 1'b1, 0, 2, 4, 0);
    checks++;
    if (hs_total !== 4 || last_hs - first_hs !== 6) begin
      failures++;
      $display("FAIL stall_timing: got hs=%0d span=%0d want 4 6", hs_total, last_hs - first_hs);
    end
  endtask

  task automatic test_reset_mid_burst();
    run_burst(12'h3A5, 8'd5, 100, 0, 1'b1, 0, 0, -1, 3);
    reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || read_ready !== 1'b0
        || read_select !== 12'd0 || rsp_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid: got rv=%b rr=%b rd=%b sel=%h data=%h want 0 1 0 0 0",
               rsp_valid, req_ready, read_ready, read_select, rsp_data);
    end
    dev_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycles(4);
    run_burst(12'h0C3, 8'd1, 100, 100, 1'b0, 0, 0, -1, 0);
    checks++;
    if (pop_total !== 2) begin
      failures++;
      $display("FAIL reset_new_burst: got %0d words want 2", pop_total);
    end
    idle_cycles(6);
  endtask

  task automatic test_max_length();
    run_burst(12'hFFF, 8'd255, 80, 80, 1'b0, 0, 0, -1, 0);
    checks++;
    if (hs_total !== 256 || pop_total !== 256) begin
      failures++;
      $display("FAIL max_length: got hs=%0d pops=%0d want 256 256", hs_total, pop_total);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 8; b++) begin
      run_burst(12'($urandom), 8'($urandom_range(20)), $urandom_range(30, 100),
                $urandom_range(30, 100), 1'b0, 0, 0, -1, 0);
    end
    idle_cycles(5);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_device_stall();
    test_reset_mid_burst();
    test_max_length();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
